// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline encodings for the hazard controller: load result select,
// forwarding-mux selects and the memory-wait FSM state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } fsm_state_t;

    // The MEM-stage producer is younger than WB, so its value wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: +1 per cycle while inc_i is high, holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: forwarding selects, stall/flush
// controls, memory-wait FSM with timeout watchdog and perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);
    import hazard_ctrl_pkg::*;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    logic mem_stall;
    logic lw_stall;

    fsm_state_t      state_q;
    logic [WC_W-1:0] wait_cnt_q;
    logic [WC_W-1:0] wait_cnt_d;
    logic            timeout_err_q;

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign mem_stall = MemReqM & ~MemReadyM;
    assign lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

    // A memory freeze holds every stage, including a taken branch sitting in EX.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                FlushD = PCSrcE;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign wait_cnt_d = wait_cnt_q + 1'b1;

    // The watchdog only flags; the pipeline keeps stalling until memory answers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    wait_cnt_q <= '0;
                    if (mem_stall)
                        state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q != WC_MAX) begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d == WC_MAX)
                            timeout_err_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign mem_timeout_err = timeout_err_q;

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (lw_stall & ~mem_stall),
        .cnt_o (lu_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (mem_stall),
        .cnt_o (mem_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (PCSrcE & ~mem_stall),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short watchdog and 4-bit counters.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [3:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
    logic       mem_timeout_err;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .RdM             (RdM),
        .RdW             (RdW),
        .ResultSrcE      (ResultSrcE),
        .RegWriteM       (RegWriteM),
        .RegWriteW       (RegWriteW),
        .PCSrcE          (PCSrcE),
        .MemReqM         (MemReqM),
        .MemReadyM       (MemReadyM),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .StallF          (StallF),
        .StallD          (StallD),
        .StallE          (StallE),
        .StallM          (StallM),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .FlushW          (FlushW),
        .lu_stall_cnt    (lu_stall_cnt),
        .mem_stall_cnt   (mem_stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout_err (mem_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0; ResultSrcE = 2'b00;
        RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // Packs the seven control outputs as {F,D,E,M,FlushD,FlushE,FlushW}.
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        #12;
        chk("rst_ctl_forced0", ctl(), 7'b0000000);
        chk("rst_lu_cnt", lu_stall_cnt, 0);
        chk("rst_mem_cnt", mem_stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_err", mem_timeout_err, 0);
        idle();
        #2 reset = 1'b0;
        tick();

        // Forwarding priority
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 9;
        #1;
        chk("fwdA_mem", ForwardAE, 2'b10);
        chk("fwdB_none", ForwardBE, 2'b00);
        chk("fwd_ctl_idle", ctl(), 7'b0000000);
        RdM = 0;
        #1 chk("fwdA_wb_rdm0", ForwardAE, 2'b01);
        RegWriteW = 0;
        #1 chk("fwdA_rf", ForwardAE, 2'b00);
        Rs2E = 7; RdW = 7; RegWriteW = 1; RdM = 7; RegWriteM = 0;
        #1 chk("fwdB_wb", ForwardBE, 2'b01);
        idle();
        tick();

        // Load-use
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        #1 chk("lu_ctl", ctl(), 7'b1100010);
        tick();
        RdE = 0;
        #1 chk("lu_next_ctl", ctl(), 7'b0000000);
        chk("lu_cnt1", lu_stall_cnt, 1);
        RdE = 3; Rs1D = 3; Rs2D = 0; PCSrcE = 1;
        #1 chk("lu_branch_ctl", ctl(), 7'b1100110);
        tick();
        idle();
        #1 chk("lu_cnt2", lu_stall_cnt, 2);
        chk("flush_cnt1", flush_cnt, 1);

        // Taken branch alone
        PCSrcE = 1;
        #1 chk("br_ctl", ctl(), 7'b0000110);
        tick();
        PCSrcE = 0;
        #1 chk("br_after_ctl", ctl(), 7'b0000000);
        chk("flush_cnt2", flush_cnt, 2);

        // Memory wait with a taken branch held in EX
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("mw_ctl_%0d", i), ctl(), 7'b1111001);
            tick();
        end
        MemReadyM = 1;
        #1 chk("mw_ready_ctl", ctl(), 7'b0000110);
        chk("mw_cnt4", mem_stall_cnt, 4);
        chk("mw_flush_held", flush_cnt, 2);
        tick();
        idle();
        #1 chk("mw_flush_cnt3", flush_cnt, 3);

        // Ready in the request cycle
        MemReqM = 1; MemReadyM = 1;
        #1 chk("same_cycle_ctl", ctl(), 7'b0000000);
        tick();
        idle();
        #1 chk("same_cycle_cnt", mem_stall_cnt, 4);

        // Watchdog
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("wd_not_yet", mem_timeout_err, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("wd_set", mem_timeout_err, 1);
        chk("wd_stall_continues", StallF, 1);
        MemReadyM = 1;
        tick();
        idle();
        tick();
        chk("wd_sticky", mem_timeout_err, 1);
        chk("wd_mem_cnt14", mem_stall_cnt, 14);

        // Async reset in the middle of a wait
        MemReqM = 1; MemReadyM = 0;
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_err", mem_timeout_err, 0);
        chk("mid_rst_mem_cnt", mem_stall_cnt, 0);
        chk("mid_rst_flush_cnt", flush_cnt, 0);
        chk("mid_rst_lu_cnt", lu_stall_cnt, 0);
        chk("mid_rst_ctl", ctl(), 7'b0000000);
        #1 reset = 1'b0;
        #1 chk("post_rst_stall", StallF, 1);

        // Saturation
        for (int i = 0; i < 20; i++) tick();
        chk("sat_mem_cnt", mem_stall_cnt, 15);
        MemReadyM = 1;
        tick();
        idle();
        tick();
        chk("sat_hold", mem_stall_cnt, 15);
        chk("sat_ctl_idle", ctl(), 7'b0000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
